// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline stages and the stall/flush sequencer.
// The pipeline side is the master: it raises requests and consumes stall/flush/redirect.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_len;
    logic              excp_req;
    logic              perf_clr;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              mc_busy;
    logic              mc_last;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_len, excp_req, perf_clr,
        input  stall, flush, new_pc, mc_busy, mc_last, stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_len, excp_req, perf_clr,
        output stall, flush, new_pc, mc_busy, mc_last, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline: merges stall requests, runs
// multi-cycle EX ops on a down-counter, and issues exception flushes.
module pipe_ctrl #(
    parameter int          CNT_W    = 6,
    parameter logic [31:0] EXCP_VEC = 32'h0000_0020,
    parameter int          PERF_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, MC_RUN} state_t;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] perf_cnt;

    logic [5:0]        stall_c;
    logic              flush_c;
    logic              last_c;
    logic              mc_go;

    // A multi-cycle op only enters MC_RUN when it needs more than the start cycle.
    assign mc_go = (state == IDLE) && bus.mc_start && (bus.mc_len >= CNT_W'(2));

    always_comb begin
        stall_c = 6'b0;
        flush_c = 1'b0;
        last_c  = 1'b0;
        if (bus.excp_req) begin
            flush_c = 1'b1;
        end else if (state == MC_RUN) begin
            stall_c = STALL_EX;
            last_c  = (cnt == CNT_W'(1));
        end else if (bus.mc_start && (bus.mc_len != '0)) begin
            stall_c = STALL_EX;
            last_c  = (bus.mc_len == CNT_W'(1));
        end else if (bus.stallreq_ex) begin
            stall_c = STALL_EX;
        end else if (bus.stallreq_id) begin
            stall_c = STALL_ID;
        end
    end

    // cnt holds the MC_RUN cycles still to come, including the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.excp_req) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_go) begin
                        state <= MC_RUN;
                        cnt   <= bus.mc_len - CNT_W'(1);
                    end
                end
                MC_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt <= '0;
        end else if (bus.perf_clr) begin
            perf_cnt <= '0;
        end else if ((stall_c != 6'b0) && !(&perf_cnt)) begin
            perf_cnt <= perf_cnt + PERF_W'(1);
        end
    end

    // Outputs are forced quiet for as long as reset is held, independent of the clock.
    assign bus.stall     = rst ? stall_c : 6'b0;
    assign bus.flush     = rst & flush_c;
    assign bus.new_pc    = (rst && flush_c) ? EXCP_VEC : 32'h0;
    assign bus.mc_busy   = rst && (state == MC_RUN);
    assign bus.mc_last   = rst & last_c;
    assign bus.stall_cnt = rst ? perf_cnt : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a remaining-cycles model checked every cycle,
// plus hand-computed literal checks; a PERF_W=4 twin exercises saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pipe_ctrl_if #(.CNT_W(6), .PERF_W(32)) bus ();
    pipe_ctrl_if #(.CNT_W(6), .PERF_W(4))  bus_s ();

    pipe_ctrl #(.CNT_W(6), .EXCP_VEC(32'h0000_0020), .PERF_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pipe_ctrl #(.CNT_W(6), .EXCP_VEC(32'h0000_0020), .PERF_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    assign bus_s.stallreq_id = bus.stallreq_id;
    assign bus_s.stallreq_ex = bus.stallreq_ex;
    assign bus_s.mc_start    = bus.mc_start;
    assign bus_s.mc_len      = bus.mc_len;
    assign bus_s.excp_req    = bus.excp_req;
    assign bus_s.perf_clr    = bus.perf_clr;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic id, input logic ex, input logic mcs,
                                  input logic [5:0] len, input logic excp, input logic clr);
        @(posedge clk);
        #1;
        bus.stallreq_id = id;
        bus.stallreq_ex = ex;
        bus.mc_start    = mcs;
        bus.mc_len      = len;
        bus.excp_req    = excp;
        bus.perf_clr    = clr;
        @(negedge clk);
        #1;
    endtask

    // Model: rem = stalled MC cycles still owed; counters tracked as plain integers.
    int     rem     = 0;
    longint m_cnt   = 0;
    int     m_cnt_s = 0;

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_last;
        logic        e_busy;
        logic [31:0] e_pc;
        int          rem_next;
        e_stall  = 6'b0;
        e_flush  = 1'b0;
        e_last   = 1'b0;
        e_busy   = 1'b0;
        e_pc     = 32'h0;
        rem_next = rem;
        if (!rst) begin
            rem     = 0;
            m_cnt   = 0;
            m_cnt_s = 0;
            rem_next = 0;
        end else begin
            e_busy = (rem > 0);
            if (bus.excp_req) begin
                e_flush  = 1'b1;
                e_pc     = 32'h20;
                rem_next = 0;
            end else if (rem > 0) begin
                e_stall  = 6'b001111;
                e_last   = (rem == 1);
                rem_next = rem - 1;
            end else if (bus.mc_start && bus.mc_len != 0) begin
                e_stall  = 6'b001111;
                e_last   = (bus.mc_len == 1);
                rem_next = int'(bus.mc_len) - 1;
            end else if (bus.stallreq_ex) begin
                e_stall = 6'b001111;
            end else if (bus.stallreq_id) begin
                e_stall = 6'b000111;
            end
        end
        check_output("m_stall",   64'(bus.stall),       64'(e_stall));
        check_output("m_flush",   64'(bus.flush),       64'(e_flush));
        check_output("m_new_pc",  64'(bus.new_pc),      64'(e_pc));
        check_output("m_mc_busy", 64'(bus.mc_busy),     64'(e_busy));
        check_output("m_mc_last", 64'(bus.mc_last),     64'(e_last));
        check_output("m_cnt32",   64'(bus.stall_cnt),   64'(m_cnt));
        check_output("m_cnt4",    64'(bus_s.stall_cnt), 64'(m_cnt_s));
        check_output("m_stall4",  64'(bus_s.stall),     64'(e_stall));
        if (rst) begin
            if (bus.perf_clr) begin
                m_cnt   = 0;
                m_cnt_s = 0;
            end else if (e_stall != 0) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt_s < 15) m_cnt_s++;
            end
            rem = rem_next;
        end
    end

    initial begin
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        bus.mc_start    = 1'b1;
        bus.mc_len      = 6'd1;
        bus.excp_req    = 1'b0;
        bus.perf_clr    = 1'b0;
        rst = 1'b0;

        #12;
        check_output("rst_stall",   64'(bus.stall),     64'h0);
        check_output("rst_mc_last", 64'(bus.mc_last),   64'h0);
        check_output("rst_cnt",     64'(bus.stall_cnt), 64'h0);
        bus.mc_start = 1'b0;
        bus.mc_len   = 6'd0;
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] T1 ID hazard");
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("t1_stall", 64'(bus.stall), 64'h07);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t1_stall_after", 64'(bus.stall), 64'h00);
        check_output("t1_cnt", 64'(bus.stall_cnt), 64'd1);

        $display("[TB] T2 multi-cycle len 4");
        apply_stimulus(0, 0, 1, 4, 0, 0);
        check_output("t2_c1_stall", 64'(bus.stall),   64'h0F);
        check_output("t2_c1_busy",  64'(bus.mc_busy), 64'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t2_c2_busy",  64'(bus.mc_busy), 64'h1);
        check_output("t2_c2_last",  64'(bus.mc_last), 64'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t2_c3_stall", 64'(bus.stall),   64'h0F);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t2_c4_last",  64'(bus.mc_last), 64'h1);
        check_output("t2_c4_busy",  64'(bus.mc_busy), 64'h1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t2_c5_stall", 64'(bus.stall),   64'h00);
        check_output("t2_c5_busy",  64'(bus.mc_busy), 64'h0);
        check_output("t2_cnt",      64'(bus.stall_cnt), 64'd5);

        $display("[TB] T3 len 1 and len 0");
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("t3_len1_stall", 64'(bus.stall),   64'h0F);
        check_output("t3_len1_last",  64'(bus.mc_last), 64'h1);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_output("t3_len0_stall", 64'(bus.stall),   64'h00);
        check_output("t3_len0_busy",  64'(bus.mc_busy), 64'h0);

        $display("[TB] T4 exception aborts op");
        apply_stimulus(0, 0, 1, 5, 0, 0);
        apply_stimulus(0, 0, 1, 3, 1, 0);
        check_output("t4_flush",  64'(bus.flush),  64'h1);
        check_output("t4_new_pc", 64'(bus.new_pc), 64'h20);
        check_output("t4_stall",  64'(bus.stall),  64'h00);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t4_busy_after",  64'(bus.mc_busy), 64'h0);
        check_output("t4_pc_after",    64'(bus.new_pc),  64'h0);

        $display("[TB] T5 merged requests");
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("t5_both", 64'(bus.stall), 64'h0F);
        apply_stimulus(1, 1, 0, 0, 1, 0);
        check_output("t5_excp_flush", 64'(bus.flush), 64'h1);
        check_output("t5_excp_stall", 64'(bus.stall), 64'h00);
        apply_stimulus(0, 0, 1, 3, 0, 0);
        apply_stimulus(0, 0, 1, 9, 0, 0);
        check_output("t5_restart_last", 64'(bus.mc_last), 64'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t5_restart_end", 64'(bus.mc_last), 64'h1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t5_idle_busy", 64'(bus.mc_busy), 64'h0);

        $display("[TB] T6 saturation and clear");
        apply_stimulus(0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t6_cleared", 64'(bus_s.stall_cnt), 64'h0);
        for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t6_sat4",  64'(bus_s.stall_cnt), 64'd15);
        check_output("t6_cnt32", 64'(bus.stall_cnt),   64'd20);
        apply_stimulus(0, 1, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("t6_clr4",  64'(bus_s.stall_cnt), 64'h0);
        check_output("t6_clr32", 64'(bus.stall_cnt),   64'h0);

        $display("[TB] async reset mid-op");
        apply_stimulus(0, 0, 1, 6, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("ar_busy_before", 64'(bus.mc_busy), 64'h1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_output("ar_stall", 64'(bus.stall),     64'h00);
        check_output("ar_busy",  64'(bus.mc_busy),   64'h0);
        check_output("ar_cnt",   64'(bus.stall_cnt), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("ar_idle_busy",  64'(bus.mc_busy), 64'h0);
        check_output("ar_idle_stall", 64'(bus.stall),   64'h00);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
